// File: rtl/regfile_pkg.sv
// Shared widths and types for the register-file writeback arbiter.
package regfile_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } wb_src_t;

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry circular buffer of writeback requests; exposes per-entry
// valid/rd so the parent can detect pending writes to a register.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  wb_req_t                      push_req,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output wb_req_t                      head,
    output logic [DEPTH-1:0]             ent_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0] ent_rd
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    wb_req_t         mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push;
    logic            do_pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Payload storage needs no reset: occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_req;
    end

    always_comb begin
        logic [PtrW-1:0] off;
        off       = '0;
        ent_valid = '0;
        ent_rd    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off          = PtrW'(i) - rd_ptr_q;
            ent_valid[i] = CntW'(off) < count_q;
            ent_rd[i]    = mem_q[i].rd;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbitration of two writeback FIFOs onto the single register-file
// write port, with combinational read-after-write hazard flags.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              reg_write,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              grant_b,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic              hazard1,
    output logic              hazard2
);

    wb_req_t                      a_req, b_req, a_head, b_head;
    logic                         a_full, a_empty, a_push, a_pop;
    logic                         b_full, b_empty, b_push, b_pop;
    logic [DEPTH-1:0]             a_ent_valid, b_ent_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] a_ent_rd, b_ent_rd;
    wb_src_t                      last_src_q;

    assign a_ready = rst_n && !a_full;
    assign b_ready = rst_n && !b_full;
    // Writes to x0 complete the handshake but are dropped here.
    assign a_push  = a_valid && a_ready && (a_rd != '0);
    assign b_push  = b_valid && b_ready && (b_rd != '0);
    assign a_req   = '{rd: a_rd, data: a_data};
    assign b_req   = '{rd: b_rd, data: b_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (a_push),
        .push_req  (a_req),
        .pop       (a_pop),
        .full      (a_full),
        .empty     (a_empty),
        .head      (a_head),
        .ent_valid (a_ent_valid),
        .ent_rd    (a_ent_rd)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (b_push),
        .push_req  (b_req),
        .pop       (b_pop),
        .full      (b_full),
        .empty     (b_empty),
        .head      (b_head),
        .ent_valid (b_ent_valid),
        .ent_rd    (b_ent_rd)
    );

    // On a tie the source not granted most recently wins.
    always_comb begin
        a_pop = 1'b0;
        b_pop = 1'b0;
        if (!a_empty && (b_empty || last_src_q == SRC_B)) begin
            a_pop = 1'b1;
        end else if (!b_empty) begin
            b_pop = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            grant_b    <= 1'b0;
            last_src_q <= SRC_B;
        end else if (a_pop) begin
            reg_write  <= 1'b1;
            write_reg  <= a_head.rd;
            write_data <= a_head.data;
            grant_b    <= 1'b0;
            last_src_q <= SRC_A;
        end else if (b_pop) begin
            reg_write  <= 1'b1;
            write_reg  <= b_head.rd;
            write_data <= b_head.data;
            grant_b    <= 1'b1;
            last_src_q <= SRC_B;
        end else begin
            reg_write  <= 1'b0;
        end
    end

    always_comb begin
        hazard1 = reg_write && (write_reg == read_reg1);
        hazard2 = reg_write && (write_reg == read_reg2);
        for (int i = 0; i < DEPTH; i++) begin
            if (a_ent_valid[i] && a_ent_rd[i] == read_reg1) hazard1 = 1'b1;
            if (b_ent_valid[i] && b_ent_rd[i] == read_reg1) hazard1 = 1'b1;
            if (a_ent_valid[i] && a_ent_rd[i] == read_reg2) hazard2 = 1'b1;
            if (b_ent_valid[i] && b_ent_rd[i] == read_reg2) hazard2 = 1'b1;
        end
        if (read_reg1 == '0) hazard1 = 1'b0;
        if (read_reg2 == '0) hazard2 = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised self-checking bench for regfile_wb_arbiter against a queue-based
// reference model and a register-file scoreboard.
module tb_regfile_wb_arbiter;

    localparam int unsigned DEPTH = 2;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready;
    logic [4:0]  a_rd = '0, b_rd = '0, read_reg1 = '0, read_reg2 = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        reg_write, grant_b, hazard1, hazard2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;

    int errors = 0;
    int checks = 0;

    // Reference model state
    req_t        m_qa[$], m_qb[$];
    bit          m_rw, m_gb, m_last_b, m_acc_a, m_acc_b;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;
    logic [31:0] m_regs [32];
    logic [31:0] dut_regs [32];
    int          m_writes, dut_writes;

    regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_rd       (a_rd),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_rd       (b_rd),
        .b_data     (b_data),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .grant_b    (grant_b),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .hazard1    (hazard1),
        .hazard2    (hazard2)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_qa.delete();
        m_qb.delete();
        m_rw     = 1'b0;
        m_gb     = 1'b0;
        m_wreg   = '0;
        m_wdata  = '0;
        m_last_b = 1'b1;
        m_acc_a  = 1'b0;
        m_acc_b  = 1'b0;
    endtask

    function automatic bit m_hazard(input logic [4:0] addr);
        if (addr == 0) return 1'b0;
        if (m_rw && m_wreg == addr) return 1'b1;
        foreach (m_qa[i]) if (m_qa[i].rd == addr) return 1'b1;
        foreach (m_qb[i]) if (m_qb[i].rd == addr) return 1'b1;
        return 1'b0;
    endfunction

    // Advance one clock: the register file snoops the DUT port, the model
    // applies the arbitration rules to its queues. Returns at edge + 1.
    task automatic step();
        bit   acc_a, acc_b, pa, pb;
        req_t r;
        if (reg_write === 1'b1) begin
            dut_regs[write_reg] = write_data;
            dut_writes++;
        end
        acc_a = rst_n && a_valid && (m_qa.size() < DEPTH);
        acc_b = rst_n && b_valid && (m_qb.size() < DEPTH);
        pa = (m_qa.size() != 0) && ((m_qb.size() == 0) || m_last_b);
        pb = (m_qb.size() != 0) && !pa;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_rw) begin
                m_regs[m_wreg] = m_wdata;
                m_writes++;
            end
            if (pa || pb) begin
                r        = pa ? m_qa.pop_front() : m_qb.pop_front();
                m_rw     = 1'b1;
                m_wreg   = r.rd;
                m_wdata  = r.data;
                m_gb     = pb;
                m_last_b = pb;
            end else begin
                m_rw = 1'b0;
            end
            if (acc_a && a_rd != 0) m_qa.push_back('{rd: a_rd, data: a_data});
            if (acc_b && b_rd != 0) m_qb.push_back('{rd: b_rd, data: b_data});
            m_acc_a = acc_a;
            m_acc_b = acc_b;
        end
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL reset_rw got=%b exp=0", reg_write); end
        checks++; if (write_reg !== 5'd0) begin errors++; $display("FAIL reset_wreg got=%0d exp=0", write_reg); end
        checks++; if (write_data !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", write_data); end
        checks++; if (grant_b !== 1'b0) begin errors++; $display("FAIL reset_grant got=%b exp=0", grant_b); end
        checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got=%b%b exp=00", a_ready, b_ready);
        end
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            errors++; $display("FAIL release_ready got=%b%b exp=11", a_ready, b_ready);
        end
    endtask

    task automatic test_contention();
        logic [4:0] la [3] = '{5'd1, 5'd2, 5'd3};
        logic [4:0] lb [3] = '{5'd8, 5'd9, 5'd10};
        logic [4:0] wexp [6] = '{5'd1, 5'd8, 5'd2, 5'd9, 5'd3, 5'd10};
        bit         gexp [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [4:0] wgot [$];
        bit         ggot [$];
        int         cyc [$];
        int         ia = 0, ib = 0;
        bit         a_blk = 0, b_blk = 0;
        for (int c = 0; c < 12; c++) begin
            a_valid = (ia < 3);
            a_rd    = la[ia % 3];
            a_data  = 32'hA000_0000 + ia;
            b_valid = (ib < 3);
            b_rd    = lb[ib % 3];
            b_data  = 32'hB000_0000 + ib;
            #1;
            if (!a_ready) a_blk = 1;
            if (!b_ready) b_blk = 1;
            checks++; if (a_ready !== (m_qa.size() < DEPTH) || b_ready !== (m_qb.size() < DEPTH)) begin
                errors++; $display("FAIL cont_ready got=%b%b exp=%b%b", a_ready, b_ready,
                                   m_qa.size() < DEPTH, m_qb.size() < DEPTH);
            end
            step();
            if (m_acc_a) ia++;
            if (m_acc_b) ib++;
            checks++; if (reg_write !== m_rw) begin
                errors++; $display("FAIL cont_rw cyc=%0d got=%b exp=%b", c, reg_write, m_rw);
            end
            if (reg_write === 1'b1) begin
                wgot.push_back(write_reg);
                ggot.push_back(grant_b);
                cyc.push_back(c);
            end
        end
        a_valid = 0;
        b_valid = 0;
        checks++; if (wgot.size() != 6) begin
            errors++; $display("FAIL cont_count got=%0d exp=6", wgot.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++; if (wgot[i] !== wexp[i] || ggot[i] !== gexp[i]) begin
                    errors++; $display("FAIL cont_order idx=%0d got=rd%0d/b%0d exp=rd%0d/b%0d",
                                       i, wgot[i], ggot[i], wexp[i], gexp[i]);
                end
            end
            checks++; if (cyc[5] - cyc[0] != 5) begin
                errors++; $display("FAIL cont_gap span got=%0d exp=5", cyc[5] - cyc[0]);
            end
        end
        checks++; if (!(a_blk && b_blk)) begin
            errors++; $display("FAIL cont_full got=%b%b exp=11", a_blk, b_blk);
        end
    endtask

    task automatic test_single_write();
        a_valid = 1; a_rd = 5'd5; a_data = 32'hDEAD_BEEF;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", a_ready); end
        step();
        a_valid = 0;
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL single_early got=%b exp=0", reg_write); end
        step();
        checks++; if (reg_write !== 1'b1 || write_reg !== 5'd5 || write_data !== 32'hDEAD_BEEF || grant_b !== 1'b0) begin
            errors++; $display("FAIL single_write got=%b/%0d/%h/%b exp=1/5/deadbeef/0",
                               reg_write, write_reg, write_data, grant_b);
        end
        step();
        checks++; if (reg_write !== 1'b0 || write_reg !== 5'd5) begin
            errors++; $display("FAIL single_after got=%b/%0d exp=0/5", reg_write, write_reg);
        end
    endtask

    task automatic test_x0_filter();
        b_valid = 1; b_rd = 5'd0; b_data = 32'h1234; read_reg1 = 5'd0;
        #1;
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got=%b exp=1", b_ready); end
        step();
        b_valid = 0;
        for (int c = 0; c < 3; c++) begin
            checks++; if (reg_write !== 1'b0 || hazard1 !== 1'b0) begin
                errors++; $display("FAIL x0_drop cyc=%0d got=%b/%b exp=0/0", c, reg_write, hazard1);
            end
            step();
        end
    endtask

    task automatic test_hazard();
        read_reg1 = 5'd3; read_reg2 = 5'd7;
        a_valid = 1; a_rd = 5'd7; a_data = $urandom;
        #1;
        checks++; if (hazard2 !== 1'b0) begin errors++; $display("FAIL haz_pre got=%b exp=0", hazard2); end
        step();
        a_valid = 0;
        checks++; if (hazard2 !== 1'b1 || reg_write !== 1'b0) begin
            errors++; $display("FAIL haz_queued got=%b/%b exp=1/0", hazard2, reg_write);
        end
        step();
        checks++; if (hazard2 !== 1'b1 || reg_write !== 1'b1 || hazard1 !== 1'b0) begin
            errors++; $display("FAIL haz_write got=%b/%b/%b exp=1/1/0", hazard2, reg_write, hazard1);
        end
        step();
        checks++; if (hazard2 !== 1'b0) begin errors++; $display("FAIL haz_clear got=%b exp=0", hazard2); end
    endtask

    task automatic test_backpressure();
        bit b_blk = 0;
        m_acc_a = 0;
        m_acc_b = 0;
        for (int c = 0; c < 300; c++) begin
            if (!a_valid || m_acc_a) begin
                a_valid = ($urandom_range(0, 9) != 0);
                a_rd    = 5'($urandom);
                a_data  = $urandom;
            end
            if (!b_valid || m_acc_b) begin
                b_valid = ($urandom_range(0, 9) != 0);
                b_rd    = 5'($urandom);
                b_data  = $urandom;
            end
            read_reg1 = 5'($urandom);
            read_reg2 = (c % 2 == 0) ? m_wreg : 5'($urandom);
            #1;
            if (!b_ready) b_blk = 1;
            checks++; if (a_ready !== (m_qa.size() < DEPTH) || b_ready !== (m_qb.size() < DEPTH)) begin
                errors++; $display("FAIL bp_ready cyc=%0d got=%b%b exp=%b%b", c, a_ready, b_ready,
                                   m_qa.size() < DEPTH, m_qb.size() < DEPTH);
            end
            checks++; if (hazard1 !== m_hazard(read_reg1) || hazard2 !== m_hazard(read_reg2)) begin
                errors++; $display("FAIL bp_hazard cyc=%0d got=%b%b exp=%b%b", c, hazard1, hazard2,
                                   m_hazard(read_reg1), m_hazard(read_reg2));
            end
            checks++; if (reg_write !== m_rw || (m_rw && (write_reg !== m_wreg ||
                          write_data !== m_wdata || grant_b !== m_gb))) begin
                errors++; $display("FAIL bp_port cyc=%0d got=%b/%0d/%h/%b exp=%b/%0d/%h/%b", c,
                                   reg_write, write_reg, write_data, grant_b, m_rw, m_wreg, m_wdata, m_gb);
            end
            step();
        end
        a_valid = 0;
        b_valid = 0;
        for (int c = 0; c < 2 * DEPTH + 3; c++) step();
        checks++; if (!b_blk) begin errors++; $display("FAIL bp_bfull got=0 exp=1"); end
        checks++; if (dut_writes != m_writes) begin
            errors++; $display("FAIL bp_writes got=%0d exp=%0d", dut_writes, m_writes);
        end
        for (int r = 0; r < 32; r++) begin
            checks++; if (dut_regs[r] !== m_regs[r]) begin
                errors++; $display("FAIL bp_reg x%0d got=%h exp=%h", r, dut_regs[r], m_regs[r]);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        for (int c = 0; c < 3; c++) begin
            a_valid = 1; a_rd = 5'($urandom_range(1, 31)); a_data = $urandom;
            b_valid = 1; b_rd = 5'($urandom_range(1, 31)); b_data = $urandom;
            step();
        end
        #2;
        rst_n = 0;
        #1;
        checks++; if (reg_write !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
            errors++; $display("FAIL mid_reset got=%b/%b/%b exp=0/0/0", reg_write, a_ready, b_ready);
        end
        model_reset();
        step();
        step();
        rst_n = 1;
        a_valid = 0;
        b_valid = 0;
        #1;
        checks++; if (write_reg !== 5'd0 || grant_b !== 1'b0) begin
            errors++; $display("FAIL mid_regs got=%0d/%b exp=0/0", write_reg, grant_b);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (reg_write !== 1'b0) begin
                errors++; $display("FAIL mid_stale cyc=%0d got=%b exp=0", c, reg_write);
            end
        end
        a_valid = 1; a_rd = 5'd11; a_data = 32'h1111;
        b_valid = 1; b_rd = 5'd12; b_data = 32'h2222;
        step();
        a_valid = 0;
        b_valid = 0;
        step();
        checks++; if (reg_write !== 1'b1 || grant_b !== 1'b0 || write_reg !== 5'd11) begin
            errors++; $display("FAIL mid_tie1 got=%b/%b/%0d exp=1/0/11", reg_write, grant_b, write_reg);
        end
        step();
        checks++; if (reg_write !== 1'b1 || grant_b !== 1'b1 || write_reg !== 5'd12) begin
            errors++; $display("FAIL mid_tie2 got=%b/%b/%0d exp=1/1/12", reg_write, grant_b, write_reg);
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            m_regs[r]   = '0;
            dut_regs[r] = '0;
        end
        m_writes   = 0;
        dut_writes = 0;
        model_reset();
        test_reset();
        test_contention();
        test_single_write();
        test_x0_filter();
        test_hazard();
        test_backpressure();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
